cdc_bus_tx_ctrl: RTL

- Source-side controller that moves multi-bit words (frame parameters, zoom/offset, max-iteration) safely into another clock domain.
- Uses a 2-phase toggle handshake: it holds each word stable on `tx_data`, toggles `tx_req`, and waits for the destination's returned `ack_tgl`.
- `ack_tgl` is synchronized internally before use.
- It sequences the multi-bit synchronizer so that bus data is never sampled while changing. It also provides a 1-deep pending slot, so the producer stalls only when two words are outstanding.

---
 rtl/cdc_pkg.sv | 9 +
 rtl/cdc_bit_sync.sv | 25 ++
 rtl/cdc_bus_tx_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the source-side CDC bus transmit controller.
package cdc_pkg;

  typedef enum logic {IDLE, WAIT_ACK} cdc_tx_state_t;

  localparam int CDC_SYNC_STAGES_DEFAULT = 2;
  localparam int CDC_TIMEOUT_DEFAULT     = 1024;

endpackage

// File: rtl/cdc_bit_sync.sv
// Single-bit multi-flop synchronizer, reset to 0. Carries the returned ack toggle.
module cdc_bit_sync
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_bus_tx_ctrl.sv
// Source-side 2-phase toggle handshake for multi-bit words, with a 1-deep pending slot.
// Optional handshake watchdog enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_bus_tx_ctrl
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SYNC_STAGES    = CDC_SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             ack_tgl,
  output logic             done,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clr
);

  cdc_tx_state_t    state;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_data;
  logic             ack_s;
  logic             match;
  logic             accept;

  cdc_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_tgl),
    .q   (ack_s)
  );

  assign match    = (ack_s == tx_req);
  assign in_ready = !pend_valid;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == WAIT_ACK);

  // tx_data and tx_req only ever move together, so the destination never samples a changing bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data <= in_data;
            tx_req  <= ~tx_req;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!match) begin
            if (accept) begin
              pend_data  <= in_data;
              pend_valid <= 1'b1;
            end
          end else begin
            done <= 1'b1;
            if (pend_valid) begin
              tx_data    <= pend_data;
              tx_req     <= ~tx_req;
              pend_valid <= 1'b0;
            end else if (accept) begin
              tx_data <= in_data;
              tx_req  <= ~tx_req;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wd_cnt;
  logic          launch;

  assign launch = (state == IDLE && accept) ||
                  (state == WAIT_ACK && match && (pend_valid || accept));

  // Watchdog only reports; the outstanding toggle is never re-issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (err_clr) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (launch) begin
      wd_cnt <= '0;
    end else if (busy && !match && wd_cnt != TMO) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == TMO - 1'b1) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  logic        unused_err_clr;
  logic [31:0] unused_timeout;

  assign unused_err_clr = err_clr;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign err_timeout    = 1'b0;
`endif

endmodule
